io_bus_master: RTL

IO_BUS_MASTER -- requirements
Module: io_bus_master

---
 rtl/io_bus_pkg.sv | 34 +++
 rtl/io_poll_timer.sv | 40 ++++
 rtl/io_bus_master.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// io_bus_pkg
// Shared definitions for the IO bus master: command op codes, the FSM
// state encoding and the IO map addresses of the debug unit's IO_BUS.
// No ports; imported by io_bus_master and io_poll_timer.

package io_bus_pkg;

    // Command op codes as they arrive on cmd_op.
    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b01,
        OP_POLL = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    // Master FSM states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_POLL = 3'd3,
        S_RSP  = 3'd4
    } state_e;

    // IO map of the debug unit.
    localparam logic [7:0] ADDR_OUT0  = 8'h00;
    localparam logic [7:0] ADDR_READY = 8'h04;
    localparam logic [7:0] ADDR_OUT1  = 8'h08;
    localparam logic [7:0] ADDR_IN    = 8'h0c;
    localparam logic [7:0] ADDR_VALID = 8'h10;

    localparam int TIMER_W = 16;

endpackage

// File: rtl/io_poll_timer.sv
// io_poll_timer
// Counts POLL cycles that saw no toggle and flags the cycle in which the
// allowed number of POLL cycles has been used up.
// Ports:
//   clk      rising-edge clock
//   rstn     asynchronous active-low reset, clears the count
//   clear    synchronous clear (held while the master is not polling)
//   enable   count this cycle
//   expired  this is the LIMIT-th counted POLL cycle

module io_poll_timer
    import io_bus_pkg::*;
#(
    parameter logic [TIMER_W-1:0] LIMIT = 16'hFFFF
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    // The count is 0 in the first POLL cycle, so the LIMIT-th cycle is the
    // one where count equals LIMIT-1; flagging it there makes the master
    // leave POLL after exactly LIMIT cycles.
    assign expired = (count == TIMER_W'(LIMIT - 1'b1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/io_bus_master.sv
// io_bus_master
// Single-outstanding command master for the debug unit's IO_BUS. Accepts
// RD / WR / POLL commands, performs the bus access, and presents one
// response that is held until the consumer takes it.
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_addr, cmd_wdata   command fields
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_err             response payload
//   io_addr, io_dout, io_we       IO bus drive
//   io_din                        IO bus read data (combinational from io_addr)
//   busy                          FSM not idle

module io_bus_master
    import io_bus_pkg::*;
#(
    parameter logic [15:0] POLL_TIMEOUT = 16'hFFFF,
    parameter logic [7:0]  VALID_ADDR   = ADDR_VALID
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [7:0]  io_addr,
    output logic [31:0] io_dout,
    output logic        io_we,
    input  logic [31:0] io_din,
    output logic        busy
);

    state_e      state;
    state_e      next_state;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic        last_valid;
    logic        timer_clear;
    logic        timer_en;
    logic        timer_expired;
    logic        toggle;

    // A POLL completes as soon as the VALID bit differs from the last value seen.
    assign toggle = (io_din[0] != last_valid);

    io_poll_timer #(
        .LIMIT (POLL_TIMEOUT)
    ) u_poll_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and all outputs decode straight from the state register, so
    // an asynchronous reset drops the bus strobe without waiting for a clock.
    // The timer is held clear everywhere except POLL, which gives the clear
    // on POLL entry. A toggle is checked before the timeout so it wins a tie.
    always_comb begin
        next_state  = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        rsp_err     = 1'b0;
        io_addr     = '0;
        io_dout     = '0;
        io_we       = 1'b0;
        timer_clear = 1'b1;
        timer_en    = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_RD:   next_state = S_RD;
                        OP_WR:   next_state = S_WR;
                        OP_POLL: next_state = S_POLL;
                        default: next_state = S_RSP;
                    endcase
                end
            end
            S_RD: begin
                io_addr    = addr_q;
                next_state = S_RSP;
            end
            S_WR: begin
                io_addr    = addr_q;
                io_dout    = wdata_q;
                io_we      = 1'b1;
                next_state = S_RSP;
            end
            S_POLL: begin
                io_addr     = VALID_ADDR;
                timer_clear = 1'b0;
                if (toggle) begin
                    next_state = S_RSP;
                end else begin
                    timer_en = 1'b1;
                    if (timer_expired) begin
                        next_state = S_RSP;
                    end
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                rsp_data  = rsp_data_q;
                rsp_err   = rsp_err_q;
                if (rsp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Command fields are latched on acceptance, and the response payload is
    // preset to "no data" with the error set only for the reserved op, so
    // WR and the reserved op need no further payload update. The op itself
    // only steers the FSM at acceptance and is not kept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            last_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q     <= cmd_addr;
                        wdata_q    <= cmd_wdata;
                        rsp_data_q <= '0;
                        rsp_err_q  <= (cmd_op == OP_RSVD);
                    end
                end
                S_RD: begin
                    rsp_data_q <= io_din;
                    if (addr_q == VALID_ADDR) begin
                        last_valid <= io_din[0];
                    end
                end
                S_POLL: begin
                    if (toggle) begin
                        rsp_data_q <= {31'b0, io_din[0]};
                        rsp_err_q  <= 1'b0;
                        last_valid <= io_din[0];
                    end else if (timer_expired) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
